data_mem_arb: RTL and testbench
===============================

DATA_MEM_ARB -- requirements
Module: data_mem_arb

Interface
REQ-001 SHALL have parameter ENTRIES, default 32, giving the data memory size in bytes.
REQ-002 SHALL have parameter AW, default clogb2(ENTRIES-1), giving the byte-address width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports req0/req1, input, 1: access request from port 0 (CPU) and port 1 (loader/DMA).
REQ-006 SHALL have ports we0/we1, input, 1: 1 means write, 0 means read.
REQ-007 SHALL have ports addr0/addr1, input, AW: byte address.
REQ-008 SHALL have ports wdata0/wdata1, input, 32: write data.
REQ-009 SHALL have ports gnt0/gnt1, output, 1: one-cycle grant pulse; command has been accepted.
REQ-010 SHALL have ports done0/done1, output, 1: one-cycle completion pulse.
REQ-011 SHALL have ports err0/err1, output, 1: error flag, valid with done.
REQ-012 SHALL have port rdata, output, 32: read data, shared by both ports, valid with done.
REQ-013 SHALL have port busy, output, 1: high when the FSM is not in IDLE.
REQ-014 SHALL have port mem_addr, output, AW: address to the data memory.
REQ-015 SHALL have ports mem_rd/mem_wr, output, 1: read and write strobes to the data memory.
REQ-016 SHALL have port mem_wdata, output, 32: big-endian write word.
REQ-017 SHALL have port mem_rdata, input, 32: read word from the data memory.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS and DONE; IDLE->ACCESS on any sampled req, ACCESS->DONE unconditionally, DONE->IDLE unconditionally.
REQ-019 SHALL, in IDLE with exactly one req high, select that port.
REQ-020 SHALL, in IDLE with both reqs high, select the port other than last_owner (round-robin).
REQ-021 SHALL, on the IDLE->ACCESS edge, latch the winner's id, we, addr and wdata, and update last_owner to the winner.
REQ-022 SHALL assert the winner's gnt for exactly the ACCESS cycle.
REQ-023 SHALL drive, in ACCESS, mem_addr, mem_wdata and mem_rd=~we or mem_wr=we from the latched command, stable for the whole cycle, because the memory writes on the falling edge.
REQ-024 SHALL hold mem_rd and mem_wr at 0 in IDLE and DONE; mem_addr and mem_wdata hold their last latched values.
REQ-025 SHALL, on the ACCESS->DONE edge, capture mem_rdata into rdata for a read, and leave rdata unchanged for a write.
REQ-026 SHALL, in DONE, pulse done for the owner only, with err0/err1 valid for that cycle.
REQ-027 SHALL hold rdata until the next read completes.
REQ-028 SHALL give a fixed latency: req sampled at edge N -> gnt during cycle N+1 -> done during cycle N+2; one access per 3 cycles maximum.
REQ-029 SHALL treat a command as illegal when addr[1:0]!=0 or addr>ENTRIES-4.
REQ-030 SHALL, for an illegal command, still traverse ACCESS with mem_rd=mem_wr=0, then in DONE set err=1 and set rdata=0.
REQ-031 SHALL leave err=0 for legal commands.
REQ-032 SHALL require a requester to hold req, we, addr and wdata stable until its gnt; changes after gnt SHALL be ignored.
REQ-033 SHALL sample a req still high in DONE only at the next IDLE, where it counts as a new request.
REQ-034 SHALL treat a req dropped before grant as withdrawn, with no access.

Reset
REQ-035 SHALL, while rst=0, asynchronously force state=IDLE, last_owner=1, gnt/done/err=0, mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0, rdata=0 and busy=0.
REQ-036 SHALL, on rst assertion during ACCESS, drop mem_wr immediately, abort the access and issue no done.
REQ-037 SHALL, after rst release, grant port 0 first on simultaneous requests.

Verification
REQ-038 SHALL cover: port0 write addr=8, wdata=0x11223344, then port0 read addr=8 -> gnt0 one cycle; done0 two cycles after sampling; rdata=0x11223344, err0=0.
REQ-039 SHALL cover: req0 and req1 both held high continuously -> grants alternate 0,1,0,1; each done appears 1 cycle after its gnt; no done to the non-owner.
REQ-040 SHALL cover: port1 read addr=5 (misaligned), and separately addr=ENTRIES-2 -> mem_rd=mem_wr=0 throughout; done1 with err1=1, rdata=0.
REQ-041 SHALL cover: rst pulsed low in the ACCESS cycle of a write to addr=12 -> mem_wr falls immediately; no done; memory word at 12 unchanged; the next simultaneous request goes to port 0.
REQ-042 SHALL cover: addr0 changed right after gnt0 on a read -> access uses the original latched address; busy=1 from ACCESS through DONE, 0 in IDLE.

Source files
------------

// File: rtl/data_mem_arb.sv
// ----------------------------------------------------------------------------
// data_mem_arb
//   Two-port arbiter in front of a single-ported word-wide data memory.
//   Port 0 is the CPU and port 1 is the loader/DMA. One access is serviced at a
//   time through a fixed three-state sequence (IDLE -> ACCESS -> DONE). When
//   both ports request at once, the port that did not win last time gets the
//   memory (round-robin).
//
// Ports
//   clk            single clock, rising-edge state updates
//   rst            asynchronous active-low reset
//   req0/req1      access request per port
//   we0/we1        1 = write, 0 = read
//   addr0/addr1    byte address (AW bits)
//   wdata0/wdata1  32-bit write data
//   gnt0/gnt1      one-cycle pulse: command accepted (the ACCESS cycle)
//   done0/done1    one-cycle pulse: command finished (the DONE cycle)
//   err0/err1      illegal-command flag, valid together with done
//   rdata          shared read data, held until the next read completes
//   busy           high whenever the sequencer is not idle
//   mem_addr       address to the data memory
//   mem_rd/mem_wr  read/write strobes, only ever high in ACCESS
//   mem_wdata      big-endian write word to the memory
//   mem_rdata      read word from the memory
//   dbg_state      current sequencer state, for observation only
//
// Handshake: a requester raises reqN with weN/addrN/wdataN and keeps all of
//   them stable until it sees gntN. The command is captured on the edge that
//   moves the sequencer out of IDLE, so anything changed after gntN is ignored.
//   A request dropped before it is granted is simply withdrawn. A request still
//   high after its own done is sampled again at the next IDLE as a fresh one.
// ----------------------------------------------------------------------------
module data_mem_arb #(
  parameter int ENTRIES = 32,
  // Bits needed to represent ENTRIES-1.
  parameter int AW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          err0,
  output logic          err1,
  output logic [31:0]   rdata,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  // Highest byte address at which a full word still fits in the memory.
  localparam logic [31:0] LAST_WORD = 32'(ENTRIES - 4);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          illegal_q, illegal_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          sel_port;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic          sel_illegal;

  // Winner selection: a lone requester wins outright; on a tie the port that
  // was not last served wins.
  always_comb begin
    sel_port = 1'b0;
    if (req0 && req1) begin
      sel_port = ~last_owner_q;
    end else begin
      sel_port = req1;
    end
  end

  assign sel_we      = sel_port ? we1    : we0;
  assign sel_addr    = sel_port ? addr1  : addr0;
  assign sel_wdata   = sel_port ? wdata1 : wdata0;
  assign sel_illegal = (sel_addr[1:0] != 2'b00) || (32'(sel_addr) > LAST_WORD);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    illegal_d    = illegal_q;
    rdata_d      = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d      = S_ACCESS;
          owner_d      = sel_port;
          last_owner_d = sel_port;
          we_d         = sel_we;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          illegal_d    = sel_illegal;
        end
      end
      S_ACCESS: begin
        state_d = S_DONE;
        // An illegal command of either kind reports zero read data.
        if (illegal_q) begin
          rdata_d = '0;
        end else if (!we_q) begin
          rdata_d = mem_rdata;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      // Reset leaves port 1 as last served so port 0 wins the first tie.
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      illegal_q    <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      illegal_q    <= illegal_d;
      rdata_q      <= rdata_d;
    end
  end

  // Strobes and pulses are decoded straight from the state register, so an
  // asynchronous reset in ACCESS removes mem_wr before the memory's falling
  // write edge and no done can follow.
  logic in_access;
  logic in_done;

  assign in_access = (state_q == S_ACCESS);
  assign in_done   = (state_q == S_DONE);

  assign gnt0      = in_access & ~owner_q;
  assign gnt1      = in_access &  owner_q;
  assign done0     = in_done   & ~owner_q;
  assign done1     = in_done   &  owner_q;
  assign err0      = done0 & illegal_q;
  assign err1      = done1 & illegal_q;

  assign mem_rd    = in_access & ~illegal_q & ~we_q;
  assign mem_wr    = in_access & ~illegal_q &  we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign rdata     = rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_arb.sv
// ----------------------------------------------------------------------------
// tb_data_mem_arb
//   Directed and randomized bench for data_mem_arb. A word-wide memory with a
//   falling-edge write sits behind the DUT; a transaction-level model (word
//   array, last served port, held read data) predicts every grant, completion,
//   error flag and read word.
// ----------------------------------------------------------------------------
module tb_data_mem_arb;

  localparam int ENTRIES = 32;
  localparam int AW      = $clog2(ENTRIES);
  localparam int WORDS   = ENTRIES / 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [31:0]   wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0]   rdata;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [1:0]    dbg_state;

  data_mem_arb #(.ENTRIES(ENTRIES), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .err0      (err0),
    .err1      (err1),
    .rdata     (rdata),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- data memory behind the DUT ----------------
  logic [31:0] mem [WORDS];
  always @(negedge clk) begin
    if (mem_wr) mem[mem_addr >> 2] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr >> 2];

  // ---------------- reference model ----------------
  logic [31:0] exp_mem [WORDS];
  int          last_owner_m = 1;
  logic [31:0] rdata_m = '0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input int a);
    return (a % 4 == 0) && (a <= ENTRIES - 4);
  endfunction

  // Runs one full access. Caller sets req/we/addr/wdata while the DUT is idle;
  // returns at the falling edge of the following idle cycle.
  task automatic do_round(input bit scramble, output int winner);
    bit          w_we;
    int          w_addr;
    logic [31:0] w_wd;
    bit          legal;
    logic [31:0] exp_rdata;

    if (req0 && req1) winner = (last_owner_m == 0) ? 1 : 0;
    else if (req0)    winner = 0;
    else              winner = 1;

    w_we   = (winner == 0) ? we0 : we1;
    w_addr = (winner == 0) ? int'(addr0) : int'(addr1);
    w_wd   = (winner == 0) ? wdata0 : wdata1;
    legal  = is_legal(w_addr);

    if (!legal)     exp_rdata = '0;
    else if (!w_we) exp_rdata = exp_mem[w_addr / 4];
    else            exp_rdata = rdata_m;

    // ACCESS cycle
    @(posedge clk); @(negedge clk);
    chk("acc_gnt0", gnt0, winner == 0);
    chk("acc_gnt1", gnt1, winner == 1);
    chk("acc_done", {done0, done1}, 0);
    chk("acc_busy", busy, 1);
    chk("acc_mem_rd", mem_rd, legal && !w_we);
    chk("acc_mem_wr", mem_wr, legal && w_we);
    chk("acc_mem_addr", mem_addr, w_addr);
    if (legal && w_we) chk("acc_mem_wdata", mem_wdata, w_wd);

    // The granted requester may now change its command freely.
    if (scramble) begin
      if (winner == 0) begin
        addr0 = AW'($urandom_range(0, ENTRIES - 1)); we0 = ~we0; wdata0 = $urandom;
      end else begin
        addr1 = AW'($urandom_range(0, ENTRIES - 1)); we1 = ~we1; wdata1 = $urandom;
      end
    end

    last_owner_m = winner;
    if (legal && w_we) exp_mem[w_addr / 4] = w_wd;
    rdata_m = exp_rdata;

    // DONE cycle
    @(posedge clk); @(negedge clk);
    chk("done_done0", done0, winner == 0);
    chk("done_done1", done1, winner == 1);
    chk("done_err0", err0, (winner == 0) && !legal);
    chk("done_err1", err1, (winner == 1) && !legal);
    chk("done_rdata", rdata, exp_rdata);
    chk("done_gnt", {gnt0, gnt1}, 0);
    chk("done_strobes", {mem_rd, mem_wr}, 0);
    chk("done_busy", busy, 1);
    chk("done_mem_addr", mem_addr, w_addr);

    // IDLE cycle
    @(posedge clk); @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_pulses", {gnt0, gnt1, done0, done1, err0, err1}, 0);
    chk("idle_rdata", rdata, exp_rdata);
    chk("idle_mem_addr", mem_addr, w_addr);
  endtask

  task automatic rand_cmd(input int p);
    logic          we;
    logic [AW-1:0] a;
    logic [31:0]   d;
    we = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(0, ENTRIES - 1));
    else                           a = AW'($urandom_range(0, WORDS - 1) * 4);
    d = $urandom;
    if (p == 0) begin we0 = we; addr0 = a; wdata0 = d; end
    else        begin we1 = we; addr1 = a; wdata1 = d; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;

    // Reset state
    #2;
    chk("rst_gnt_done_err", {gnt0, gnt1, done0, done1, err0, err1}, 0);
    chk("rst_strobes", {mem_rd, mem_wr}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fill the memory through port 1
    for (int i = 0; i < WORDS; i++) begin
      req1 = 1; we1 = 1; addr1 = AW'(i * 4); wdata1 = $urandom;
      do_round(1'b0, w);
      req1 = 0;
    end
    for (int i = 0; i < WORDS; i++) chk("fill_mem", mem[i], exp_mem[i]);

    // Port 0 write then read back at address 8
    req0 = 1; we0 = 1; addr0 = AW'(8); wdata0 = 32'h1122_3344;
    do_round(1'b0, w);
    we0 = 0;
    do_round(1'b0, w);
    req0 = 0;
    chk("rd8_value", rdata, 32'h1122_3344);

    // Illegal reads on port 1, plus the last legal word
    req1 = 1; we1 = 0; addr1 = AW'(5);
    do_round(1'b0, w);
    chk("misaligned_rdata", rdata, 0);
    addr1 = AW'(ENTRIES - 4);
    do_round(1'b0, w);
    addr1 = AW'(ENTRIES - 2);
    do_round(1'b0, w);
    chk("overrun_rdata", rdata, 0);
    req1 = 0;

    // Both held: grants alternate starting with port 0
    req0 = 1; we0 = 0; addr0 = AW'(8);
    req1 = 1; we1 = 1; addr1 = AW'(4); wdata1 = $urandom;
    for (int i = 0; i < 4; i++) begin
      do_round(1'b0, w);
    end
    req0 = 0; req1 = 0;

    // Command changed right after grant is ignored
    req0 = 1; we0 = 0; addr0 = AW'(8);
    do_round(1'b1, w);
    req0 = 0;
    chk("scramble_rdata", rdata, 32'h1122_3344);

    // Withdrawn request never gets served
    req1 = 1; we1 = 1; addr1 = AW'(0); wdata1 = ~exp_mem[0];
    #2 req1 = 0;
    @(negedge clk);
    chk("withdrawn_busy", busy, 0);
    chk("withdrawn_gnt", gnt1, 0);
    @(negedge clk);
    chk("withdrawn_mem", mem[0], exp_mem[0]);

    // Reset during ACCESS of a write to 12
    req0 = 1; we0 = 0; addr0 = AW'(16);
    do_round(1'b0, w);                    // port 0 is now last served
    we0 = 1; addr0 = AW'(12); wdata0 = ~exp_mem[3];
    @(posedge clk); #2;
    chk("pre_rst_mem_wr", mem_wr, 1);
    rst = 1'b0; #1;
    chk("rst_acc_mem_wr", mem_wr, 0);
    chk("rst_acc_gnt", gnt0, 0);
    chk("rst_acc_busy", busy, 0);
    chk("rst_acc_rdata", rdata, 0);
    chk("rst_acc_mem_addr", mem_addr, 0);
    req0 = 0;
    last_owner_m = 1;
    rdata_m = '0;
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_no_done", {done0, done1, busy}, 0);
    @(negedge clk);
    chk("rst_no_done2", {done0, done1, busy}, 0);
    chk("rst_mem12_kept", mem[3], exp_mem[3]);
    req0 = 1; we0 = 0; addr0 = AW'(12);
    req1 = 1; we1 = 0; addr1 = AW'(0);
    do_round(1'b0, w);                    // model expects port 0
    chk("post_rst_gnt_port0", rdata, exp_mem[3]);
    req0 = 0;
    do_round(1'b0, w);
    req1 = 0;

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      if (!req0 && $urandom_range(0, 2) != 0) begin req0 = 1; rand_cmd(0); end
      if (!req1 && $urandom_range(0, 2) != 0) begin req1 = 1; rand_cmd(1); end
      if (!req0 && !req1) begin req0 = 1; rand_cmd(0); end
      do_round($urandom_range(0, 3) == 0, w);
      if (w == 0) req0 = 0;
      else        req1 = 0;
    end
    req0 = 0; req1 = 0;
    @(negedge clk);
    for (int i = 0; i < WORDS; i++) chk("final_mem", mem[i], exp_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
